// File: rtl/tx_filt_pkg.sv
// tx_filt_pkg: shared widths, symbol levels and root-raised-cosine taps for the 4-ASK transmit filter
package tx_filt_pkg;
  localparam int DW = 18;
  localparam int PW = 36;
  localparam int AW = 39;
  localparam int UPS = 4;
  localparam int N_TAPS = 21;
  localparam logic signed [DW-1:0] LVL_M3 = -18'sd98304;
  localparam logic signed [DW-1:0] LVL_M1 = -18'sd32768;
  localparam logic signed [DW-1:0] LVL_P1 = 18'sd32768;
  localparam logic signed [DW-1:0] LVL_P3 = 18'sd98304;
  localparam logic signed [DW-1:0] H [0:N_TAPS-1] = '{
    18'sd2817, 18'sd4060, 18'sd2289, -18'sd2373, -18'sd7348, -18'sd8574, -18'sd2772,
    18'sd10263, 18'sd26830, 18'sd40696, 18'sd46096, 18'sd40696, 18'sd26830, 18'sd10263,
    -18'sd2772, -18'sd8574, -18'sd7348, -18'sd2373, 18'sd2289, 18'sd4060, 18'sd2817
  };
  // tap indices past the end of the filter read as zero so short phases need no special case
  function automatic logic signed [DW-1:0] coef(input logic [4:0] n);
    return n < 5'(N_TAPS) ? H[n] : '0;
  endfunction
endpackage

// File: rtl/tx_pulse_shaper_sym_map.sv
// sym_map: maps a 2-bit 4-ASK symbol to its 1s17 amplitude; invalid symbols become zero
module sym_map
  import tx_filt_pkg::*;
(
  input  logic [1:0]           sym,
  input  logic                 valid,
  output logic signed [DW-1:0] level
);
  always_comb level = !valid ? '0 : sym == 2'b11 ? LVL_P3 : sym == 2'b10 ? LVL_P1 : sym == 2'b01 ? LVL_M1 : LVL_M3;
endmodule

// File: rtl/tx_pulse_shaper.sv
// tx_pulse_shaper: 4-ASK symbol mapper with x4 polyphase root-raised-cosine interpolation
module tx_pulse_shaper #(
  parameter int N_TAPS = 21,
  parameter int UPS = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [1:0]                        sym_in,
  input  logic                              sym_valid,
  output logic                              sym_strobe,
  output logic signed [tx_filt_pkg::DW-1:0] y,
  output logic [1:0]                        y_ph
);
  import tx_filt_pkg::*;
  localparam int NS = (N_TAPS + UPS - 1) / UPS;
  logic [1:0] ph, ph_d;
  logic last;
  logic signed [DW-1:0] lvl;
  logic signed [DW-1:0] s [NS];
  logic signed [DW-1:0] c [NS];
  logic signed [PW-1:0] prod [NS];
  logic signed [AW-1:0] acc;
  assign last = ph == 2'(UPS - 1);
  assign sym_strobe = last && !reset;
  sym_map u_map (.sym(sym_in), .valid(sym_valid), .level(lvl));
  always_comb begin
    acc = '0;
    for (int k = 0; k < NS; k++) begin
      c[k] = coef(5'(UPS * k) + 5'(ph));
      acc = acc + AW'(prod[k]);
    end
  end
  // exact sum, then keep bits [34:17]: floor toward -inf, range guaranteed by the taps
  always_ff @(posedge clk) begin
    if (reset) begin
      ph <= '0;
      ph_d <= '0;
      y <= '0;
      y_ph <= '0;
      for (int k = 0; k < NS; k++) begin
        s[k] <= '0;
        prod[k] <= '0;
      end
    end else begin
      ph <= last ? '0 : ph + 2'd1;
      ph_d <= ph;
      y <= DW'(acc >>> (DW - 1));
      y_ph <= ph_d;
      for (int k = 0; k < NS; k++) prod[k] <= s[k] * c[k];
      if (last) begin
        s[0] <= lvl;
        for (int k = 1; k < NS; k++) s[k] <= s[k-1];
      end
    end
  end
endmodule

// File: tb/tb_tx_pulse_shaper.sv
// tb_tx_pulse_shaper: table-driven and scoreboard checks of the 4-ASK transmit pulse shaper
module tb_tx_pulse_shaper;
  logic clk = 0, reset = 1, sym_valid = 0, sym_strobe;
  logic [1:0] sym_in = 0, y_ph;
  logic signed [17:0] y;
  int total = 0, bad = 0, cyc = 0;
  typedef struct { int cyc; int y; int ph; } exp_t;
  typedef struct { logic [1:0] sym; logic vld; int e0; int e1; int e2; int e3; } vec_t;
  exp_t q [$];
  vec_t tbl [5];
  logic [1:0] isym [3] = '{2'b11, 2'b01, 2'b00};
  int hh [11] = '{2817, 4060, 2289, -2373, -7348, -8574, -2772, 10263, 26830, 40696, 46096};

  tx_pulse_shaper dut (.clk(clk), .reset(reset), .sym_in(sym_in), .sym_valid(sym_valid),
                       .sym_strobe(sym_strobe), .y(y), .y_ph(y_ph));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d want %0d", nm, cyc, act, want);
    end
  endtask

  always @(negedge clk)
    while (q.size() != 0 && q[0].cyc == cyc) begin
      chk("sb_y", int'(y), q[0].y);
      chk("sb_ph", int'(y_ph), q[0].ph);
      void'(q.pop_front());
    end

  function automatic int lv(input logic [1:0] sv);
    return sv == 2'b11 ? 3 : sv == 2'b10 ? 1 : sv == 2'b01 ? -1 : -3;
  endfunction

  function automatic int hb(input int n);
    return hh[n <= 10 ? n : 20 - n];
  endfunction

  task automatic send(input logic [1:0] sv, input logic vv, output int cs);
    for (int g = 0; g < 8 && !sym_strobe; g++) begin
      @(posedge clk); #1;
    end
    if (!sym_strobe) chk("strobe_wait", int'(sym_strobe), 1);
    cs = cyc;
    sym_in = sv;
    sym_valid = vv;
    @(posedge clk); #1;
    sym_valid = 0;
    sym_in = 2'($urandom);
  endtask

  task automatic drain();
    for (int g = 0; g < 64 && q.size() != 0; g++) begin
      @(posedge clk); #1;
    end
    if (q.size() != 0) begin
      chk("drain", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic post_reset(input string nm, input int n);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      chk({nm, "_y"}, int'(y), 0);
      chk({nm, "_ph"}, int'(y_ph), c < 3 ? 0 : (c - 3) % 4);
      chk({nm, "_strobe"}, int'(sym_strobe), int'(c % 4 == 0));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int cs;
    tbl[0] = '{2'b11, 1'b1, 33448, 33054, 33847, 33054};
    tbl[1] = '{2'b00, 1'b1, -33449, -33054, -33848, -33054};
    tbl[2] = '{2'b10, 1'b1, 11149, 11018, 11282, 11018};
    tbl[3] = '{2'b01, 1'b1, -11150, -11018, -11283, -11018};
    tbl[4] = '{2'b11, 1'b0, 0, 0, 0, 0};
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_y", int'(y), 0);
      chk("rst_ph", int'(y_ph), 0);
      chk("rst_strobe", int'(sym_strobe), 0);
    end
    @(posedge clk); #1;
    reset = 0;
    post_reset("rel", 12);
    foreach (tbl[i]) begin
      repeat (8) send(tbl[i].sym, tbl[i].vld, cs);
      q.push_back('{cs + 3, tbl[i].e0, 0});
      q.push_back('{cs + 4, tbl[i].e1, 1});
      q.push_back('{cs + 5, tbl[i].e2, 2});
      q.push_back('{cs + 6, tbl[i].e3, 3});
    end
    drain();
    foreach (isym[j]) begin
      repeat (6) send(2'b00, 1'b0, cs);
      send(isym[j], 1'b1, cs);
      for (int n = 0; n < 25; n++)
        q.push_back('{cs + 3 + n, n < 21 ? (lv(isym[j]) * hb(n)) >>> 2 : 0, n % 4});
    end
    drain();
    repeat (8) send(2'b11, 1'b1, cs);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    post_reset("mid", 12);
    for (int g = 0; g < 8 && !sym_strobe; g++) begin
      @(posedge clk); #1;
    end
    sym_in = 2'b11;
    sym_valid = 1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    sym_valid = 0;
    post_reset("disc", 12);
    for (int c = 0; c < 24; c++) begin
      sym_in = 2'($urandom);
      sym_valid = !sym_strobe;
      @(negedge clk);
      chk("ign_y", int'(y), 0);
      @(posedge clk); #1;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tx_pulse_shaper.md
# tx_pulse_shaper

Transmit-side square-root raised-cosine pulse shaper for the 4-ASK link. It takes one 2-bit symbol every 4 clocks, maps it to a 1s17 amplitude, and interpolates by 4 through a 21-tap symmetric polyphase filter. It produces one 1s17 sample per clock for the DAC/channel model. Its coefficient set is matched to the receive filter, so the TX/RX cascade forms a raised-cosine response.

## Interface
- `N_TAPS`, default 21: filter length; odd and symmetric.
- `UPS`, default 4: upsampling factor (samples per symbol).
- `clk` in 1: sample-rate clock.
- `reset` in 1: synchronous, active-high.
- `sym_in` in 2: symbol bits; sampled only on a strobe edge.
- `sym_valid` in 1: sampled with `sym_in`; low inserts a zero symbol (idle or impulse insertion).
- `sym_strobe` out 1: high for one cycle in every 4; `sym_in`/`sym_valid` are captured on the rising edge that ends this cycle.
- `y` out 18 signed: shaped output sample, 1s17, registered.
- `y_ph` out 2: polyphase index that produced the current `y`.

## Operation
- Phase counter `ph`:
  - Counts 0,1,2,3 and wraps.
  - `sym_strobe = (ph==3) && !reset`.
- Symbol delay line `s[0..5]`, 18-bit 1s17:
  - On the edge where `ph==3`: `s[k] <= s[k-1]`, and `s[0] <= map(sym_in)` if `sym_valid`, else 0.
  - Holds otherwise.
- Level map, 1s17:
  - 00 → -98304 (-0.75)
  - 01 → -32768 (-0.25)
  - 10 → +32768 (+0.25)
  - 11 → +98304 (+0.75)
- Polyphase, during a cycle with phase `p`:
  - acc = Σ_k h[4k+p]·s[k] over valid tap indices 4k+p ≤ 20.
  - Phase 0 uses 6 taps (k=0..5); phases 1–3 use 5 taps (k=0..4).
- Coefficients, 0s18, symmetric with h[20-n]=h[n]. h[0..10] = 2817, 4060, 2289, -2373, -7348, -8574, -2772, 10263, 26830, 40696, 46096.
- Arithmetic:
  - Each product is full 36-bit (1s17 × 0s18 = 2s34).
  - Products are summed exactly in a 39-bit accumulator.
  - `y = acc[34:17]` (truncation toward −∞). No rounding and no saturation: the worst-case |acc| stays below 0.26, so there is no overflow.
- No backpressure: the upstream source must present data on every strobe. A missing symbol is expressed only by `sym_valid=0`.

## Timing
- Pipeline:
  - Stage 1 registers the per-tap products (6 registers), with `ph` delayed alongside.
  - Stage 2 registers the sum into `y` and the delayed phase into `y_ph`.
- Latency: the state (`s`, `ph`) present in cycle t appears on `y`/`y_ph` in cycle t+2.
- A symbol captured at edge E first affects `y` (as the phase-0, h[0] term) two cycles after E, i.e. the first post-E cycle with `y_ph==0`.
- Reset (asserted on any edge, including mid-symbol) clears on that edge:
  - `ph`, all `s`, and the product registers to 0.
  - `y` to 0 and `y_ph` to 0.
  - `sym_strobe` is forced low while `reset` is high.
- First cycle after reset release: `ph=0`. The first strobe is the 4th cycle after release.
- `y` remains 0 until a valid symbol has propagated through the pipeline.
- A symbol with `sym_valid=1` on a strobe edge where `reset` is also high is discarded.
- `sym_in` changes outside strobe cycles are ignored.

## Structure
- Package `tx_filt_pkg` holds:
  - The coefficient array `H[0:20]`.
  - The 4 level constants.
  - Width localparams: `DW=18`, `PW=36`, `AW=39`.
  - `UPS` and `N_TAPS`.
- Sub-module `sym_map`: purely combinational, maps `sym_in`/`sym_valid` to a 1s17 level.
- Phase-dependent coefficient selection is a 4-way mux per tap slot. Slot k=5 is zero for phases 1–3.

## Test plan
- Reset behaviour: hold `reset` for 3 cycles, then release.
  - `y=0`, `y_ph=0` and `sym_strobe=0` during reset.
  - After release, `sym_strobe` is high in cycles 4, 8, 12, …
- Impulse: one strobe with `sym_in=11`, `valid=1`, then `valid=0` forever.
  - `y` runs through floor(0.75·h[n]) for n=0..20: 2112, 3045, 1716, -1780, -5511, …, 34572 (n=10), …, 2112.
  - `y` is 0 afterwards.
  - `y_ph` cycles 0..3, starting aligned with 2112.
- Steady state: constant `11` with `valid=1` for at least 7 symbols.
  - `y` per phase is 33448 (p0), 33054 (p1), 33847 (p2), 33054 (p3).
  - With constant `00`: -33449, -33054, -33848, -33054.
- Linearity: an impulse with `01` gives floor(-0.25·h[n]), e.g. h[0] → -705 and h[10] → -11524.
- Mid-operation reset: assert `reset` for 1 cycle during the steady state.
  - `y=0` on the next cycle.
  - The output stays 0 until new valid symbols propagate; the phase restarts at 0.
- Ignored inputs: toggle `sym_in` on non-strobe cycles with `valid=0` at strobes; `y` stays 0.
